// File: rtl/table_walker_pkg.sv
// Shared types for the descriptor-table walker: entry layout, entry size and FSM states.
package table_walker_pkg;

  localparam int TE_BYTES   = 16;
  localparam int WORD_BYTES = 8;

  // Bit order is {hi word, lo word}; lo lives at the lower memory address.
  typedef struct packed {
    logic [63:0] hi;
    logic [63:0] lo;
  } table_entry_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_LO  = 3'd1,
    S_WAIT_LO = 3'd2,
    S_REQ_HI  = 3'd3,
    S_WAIT_HI = 3'd4,
    S_EMIT    = 3'd5,
    S_FINISH  = 3'd6
  } tw_state_e;

endpackage

// File: rtl/table_walker.sv
// Walks a table of 128-bit descriptors, fetching each as two 64-bit reads and
// pushing it into the downstream object buffer one entry per five cycles at most.
module table_walker
  import table_walker_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] table_base,
  input  logic [CNT_W-1:0]  num_entries,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  emitted,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_resp_data,
  input  logic              buffer_full,
  output table_entry_t      new_entry,
  output logic              entry_valid
);

  tw_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  emitted_q, emitted_d;
  logic [63:0]       lo_q, lo_d;
  logic [63:0]       hi_q, hi_d;
  table_entry_t      last_q, last_d;
  logic              emit_s;
  logic              more_s;
  logic [ADDR_W-1:0] entry_addr_s;

  assign entry_addr_s = base_q + (ADDR_W'(idx_q) * ADDR_W'(TE_BYTES));
  assign more_s       = (({1'b0, idx_q} + (CNT_W+1)'(1)) < {1'b0, count_q});

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    idx_d     = idx_q;
    emitted_d = emitted_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    last_d    = last_q;
    emit_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d     = {CNT_W{1'b0}};
          emitted_d = {CNT_W{1'b0}};
          if (num_entries != {CNT_W{1'b0}}) begin
            base_d  = {table_base[ADDR_W-1:3], 3'b000};
            count_d = num_entries;
            state_d = S_REQ_LO;
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ_LO: begin
        if (mem_req_ready) state_d = S_WAIT_LO;
        else               state_d = S_REQ_LO;
      end
      S_WAIT_LO: begin
        if (mem_resp_valid) begin
          lo_d    = mem_resp_data;
          state_d = S_REQ_HI;
        end else begin
          state_d = S_WAIT_LO;
        end
      end
      S_REQ_HI: begin
        if (mem_req_ready) state_d = S_WAIT_HI;
        else               state_d = S_REQ_HI;
      end
      S_WAIT_HI: begin
        if (mem_resp_valid) begin
          hi_d    = mem_resp_data;
          state_d = S_EMIT;
        end else begin
          state_d = S_WAIT_HI;
        end
      end
      S_EMIT: begin
        // The >=4-cycle gap between writes means buffer_full already reflects the last push.
        if (!buffer_full) begin
          emit_s    = 1'b1;
          last_d    = {hi_q, lo_q};
          emitted_d = emitted_q + CNT_W'(1);
          idx_d     = idx_q + CNT_W'(1);
          state_d   = more_s ? S_REQ_LO : S_FINISH;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= {ADDR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      idx_q     <= {CNT_W{1'b0}};
      emitted_q <= {CNT_W{1'b0}};
      lo_q      <= 64'd0;
      hi_q      <= 64'd0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      emitted_q <= emitted_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      last_q    <= last_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FINISH);
  assign emitted       = emitted_q;
  assign mem_req_valid = (state_q == S_REQ_LO) || (state_q == S_REQ_HI);
  assign mem_req_addr  = entry_addr_s +
                         ((state_q == S_REQ_HI) ? ADDR_W'(WORD_BYTES) : {ADDR_W{1'b0}});
  assign entry_valid   = emit_s;
  assign new_entry     = emit_s ? table_entry_t'({hi_q, lo_q}) : last_q;

endmodule

// File: doc/table_walker.md
# table_walker

Fetches a message's field-descriptor table from memory, one 128-bit TABLE_ENTRY at a time, and pushes each entry into the object buffer. It sits directly upstream of the object buffer and drives that buffer's new_entry/valid_in inputs. It respects the buffer's registered full flag, which lags by one cycle, by never writing on consecutive cycles. One table walk runs per start pulse. The memory side uses a single-outstanding request/response port.

## Interface
- ADDR_W, 32, byte-address width of the memory port
- CNT_W, 16, width of entry count and index
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  one-cycle pulse; begins a walk; ignored while busy=1
- table_base  in  ADDR_W  byte address of entry 0; sampled on accepted start
- num_entries  in  CNT_W  entries to walk; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when a walk completes
- emitted  out  CNT_W  entries pushed in the current or last walk
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts the request when valid and ready are both high
- mem_req_addr  out  ADDR_W  8-byte-aligned read address
- mem_resp_valid  in  1  read data valid; arrives no earlier than the cycle after acceptance
- mem_resp_data  in  64  read data
- buffer_full  in  1  object buffer full flag (registered)
- new_entry  out  TABLE_ENTRY  entry driven to the object buffer
- entry_valid  out  1  write strobe to the object buffer's valid_in

## Operation
- FSM states: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, EMIT, FINISH.
- **IDLE**
  - On start with num_entries≠0: latch base and count, clear idx and emitted, go to REQ_LO.
  - On start with num_entries=0: go to FINISH.
- **REQ_LO**: mem_req_valid=1, addr = base + 16·idx. Go to WAIT_LO on handshake; hold the address while ready=0.
- **WAIT_LO**: on resp_valid, capture the low 64 bits of the entry, then go to REQ_HI.
- **REQ_HI**: addr = base + 16·idx + 8. Go to WAIT_HI on handshake.
- **WAIT_HI**: on resp_valid, capture the high 64 bits, then go to EMIT.
- **EMIT**
  - If buffer_full=0: entry_valid=1 for exactly one cycle, new_entry = {hi,lo}, emitted++, idx++.
  - Then go to REQ_LO if idx+1<count, else FINISH.
  - If buffer_full=1: stall in EMIT with entry_valid=0.
- **FINISH**: done=1 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; a walk may wrap past the top of memory without error.
- mem_resp_valid is ignored outside WAIT_LO and WAIT_HI. This covers stale responses after a reset.
- new_entry holds its last value when entry_valid=0.
- emitted holds its value after done until the next accepted start.

## Timing
- Reset values: busy=0, done=0, emitted=0, mem_req_valid=0, mem_req_addr=0, entry_valid=0, new_entry=0, FSM=IDLE.
- Start accepted in cycle 0:
  - busy=1 and mem_req_valid=1 from cycle 1.
  - With zero-wait memory (ready=1, response the cycle after acceptance), the first entry_valid occurs in cycle 5.
- Steady state is 5 cycles per entry. entry_valid is never high on two consecutive cycles (minimum 4-cycle gap).
  - This gap guarantees buffer_full sampled in EMIT already reflects the previous write.
- Last EMIT in cycle n: done=1 and busy=1 in cycle n+1; busy=0 from cycle n+2.
- num_entries=0: done pulses in cycle 1 and no memory request is issued.
- A start pulse during busy is dropped, including in the FINISH cycle.
- Reset asserted mid-walk: the next edge (asynchronously) forces the reset values.
  - A walk in progress is abandoned and never resumes.
  - A half-fetched entry is never emitted.

## Structure
- Shared package holds: the TABLE_ENTRY packed typedef (128 bits, bit order {hi word, lo word}), TE_BYTES=16, and the table_walker state enum.
- No sub-module: a single FSM plus datapath registers (base, count, idx, lo/hi capture).

## Test plan
- Basic walk: base=0x1000, num_entries=3, zero-wait memory → requests to 0x1000, 0x1008, 0x1010, 0x1018, 0x1020, 0x1028; three entry_valid pulses 5 cycles apart; done once; emitted=3.
- Backpressure: buffer_full=1 from before the first EMIT for 10 cycles → entry_valid=0 throughout; a single pulse the cycle full drops; entry data unchanged.
- Memory stalls: mem_req_ready low for 3 cycles and response delayed 4 cycles → addr stable while stalled; entries correct; no lost or duplicated request.
- Edge starts: num_entries=0 → done in cycle 1 with no mem_req_valid; a start during busy is ignored and emitted is unaffected.
- Wrap: base=0xFFFF_FFF0, num_entries=2 → addresses 0xFFFF_FFF0, 0xFFFF_FFF8, 0x0000_0000, 0x0000_0008.
- Reset mid-walk: assert reset in WAIT_HI of entry 1 → all outputs at reset values immediately; a stale resp_valid afterwards is ignored; a fresh walk runs correctly.
